imem_stream_loader: RTL and testbench
=====================================

Name: imem_stream_loader

Overview:
- Hardware program loader. It is the writer side of the instruction-memory image that the fetch stage reads.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into instruction memory.
- Holds the processor's PC clear until the load completes.
- Sits between a host byte source (UART RX or debug port) and the IF-stage instruction memory write port. The PC hold is driven into clr_PC of MIPS_Processor.

Parameters:
- DEPTH, 1024, number of instruction-memory words.
- ADDR_W, 10, width of the word address; must satisfy 2^ADDR_W >= DEPTH.
- BASE_ADDR, 0, word address of the first loaded instruction.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session.
- in_valid  input  1  byte source has a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid & in_ready.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse.
- imem_addr  output  ADDR_W  word write address.
- imem_wdata  output  32  instruction word.
- cpu_hold  output  1  drives the processor clr_PC; high holds PC at 0.
- done  output  1  load completed successfully (level).
- error  output  1  load aborted (level).

Behaviour:
- Reset values: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, byte counter=0, word index=0.
- Stream format: 4-byte header giving word count N (MSB first), then N words of 4 bytes each (MSB first, matching hex image order).
- States:
  - IDLE: in_ready=0. start -> HDR.
  - HDR: in_ready=1. Shifts 4 bytes into N. After the 4th byte:
    - N==0 -> DONE.
    - N>DEPTH-BASE_ADDR -> ERR.
    - otherwise -> DATA.
  - DATA: in_ready=1. Shifts bytes into a word register. After the 4th byte -> WRITE.
  - WRITE: exactly one cycle; in_ready=0, imem_we=1, imem_addr=BASE_ADDR+index, imem_wdata=assembled word. Index then increments. If index+1==N -> DONE (or CHK, see Optional Feature); else -> DATA.
  - DONE: done=1, cpu_hold=0, in_ready=0. start -> HDR and clears done.
  - ERR: error=1, cpu_hold=1, in_ready=0. start -> HDR and clears error.
- cpu_hold=1 in every state except DONE; it deasserts on the cycle after the last write.
- Latency: the write pulse occurs the cycle after the 4th byte of a word is accepted.
- Peak throughput is 4 bytes per 5 cycles.
- in_valid low mid-word stalls with no timeout; the partial word is retained.
- start is ignored in HDR, DATA and WRITE. start coincident with in_valid in IDLE: the byte is not consumed (in_ready=0 that cycle).
- Byte counter is 2 bits and wraps 3->0 on each word boundary.
- Index width is ADDR_W+1, so N==DEPTH is representable.
- Reset mid-load returns to IDLE immediately; words already written stay in memory and no further write pulse is issued.
- imem_we is never asserted outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last word, state CHK accepts one extra byte.
  - That byte must equal the XOR of all header and data bytes.
  - Match -> DONE; mismatch -> ERR.
  - Words already written remain written, but cpu_hold stays 1 on mismatch.
- Disabled: no CHK state; the stream ends after the last data byte and the transition goes straight to DONE.

Test Plan:
- Basic load: reset, start, stream 00 00 00 02, 20 01 00 05, 20 02 00 43 -> exactly two imem_we pulses (addr 0 data 0x20010005; addr 1 data 0x20020043); cpu_hold falls the cycle after the second pulse; done=1.
- Zero-length: header 00 00 00 00 -> no imem_we; done=1 and cpu_hold=0 the cycle after the 4th header byte.
- Oversize: header 00 00 04 01 (1025) with DEPTH=1024 -> error=1, cpu_hold=1, no writes; a subsequent start plus valid stream loads correctly.
- Backpressure/gaps: random in_valid gaps and a full DEPTH=1024 load -> addr 1023 written last, no dropped or duplicated bytes, in_ready=0 on every WRITE cycle.
- Reset mid-load: assert reset after word 1 of 3 -> state IDLE, cpu_hold=1, done=0, no further imem_we; word 0 contents preserved in memory.
- Checksum (IMEM_LOADER_CHECKSUM_EN): the basic-load stream followed by a correct XOR byte -> done=1; the same stream with the XOR byte flipped -> error=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_stream_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for imem_stream_loader.
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready; in_data must stay stable while in_valid waits.
interface imem_stream_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_stream_loader.sv
// Program loader: header word count N, then N big-endian words written to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte over header and data.
module imem_stream_loader #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    imem_stream_loader_if.slave    bus,
    output logic [2:0]             dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5,
        S_CHK   = 3'd6
    } state_t;

    localparam logic [31:0]       MAX_N = 32'(DEPTH - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [31:0]       n_q, n_d;
    logic [31:0]       word_q, word_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              xfer;
    logic              start_take;

    // in_ready_q mirrors the byte-accepting states, so it alone qualifies a transfer
    assign xfer       = bus.in_valid & in_ready_q;
    assign start_take = bus.start & (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (start_take) begin
            chk_d = 8'h00;
        end else if (xfer && (state_q == S_HDR || state_q == S_DATA)) begin
            chk_d = chk_q ^ bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) chk_q <= 8'h00;
        else       chk_q <= chk_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        n_d     = n_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (start_take) begin
            state_d = S_HDR;
            cnt_d   = 2'd0;
            idx_d   = '0;
            n_d     = 32'd0;
        end else begin
            case (state_q)
                S_HDR: begin
                    if (xfer) begin
                        n_d   = {n_q[23:0], bus.in_data};
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (n_d == 32'd0)   state_d = S_DONE;
                            else if (n_d > MAX_N) state_d = S_ERR;
                            else                state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        word_d = {word_q[23:0], bus.in_data};
                        cnt_d  = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = S_WRITE;
                            addr_d  = BASE + idx_q[ADDR_W-1:0];
                            wdata_d = word_d;
                        end
                    end
                end
                S_WRITE: begin
                    idx_d = idx_q + ONE;
                    if (32'(idx_d) == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) state_d = (bus.in_data == chk_q) ? S_DONE : S_ERR;
                end
`endif
                S_IDLE, S_DONE, S_ERR: state_d = state_q;
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with it
        in_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
        we_d       = (state_d == S_WRITE);
        hold_d     = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            idx_q      <= '0;
            n_q        <= 32'd0;
            word_q     <= 32'd0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            word_q     <= word_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: randomized byte streams against a stream-level model
// that checks every output on every cycle, plus literal load/zero/oversize/reset cases.
module tb_imem_stream_loader;
  localparam int DEPTH = 1024;
  localparam int ADDR_W = 10;
  localparam int BASE_ADDR = 0;
  localparam logic [31:0] MAX_N = 32'(DEPTH - BASE_ADDR);

  logic clk;
  logic reset;
  logic [2:0] dbg_state;

  imem_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0] img[$];
  logic [31:0] tb_mem [0:DEPTH-1];
  int writes_seen = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // stream-level model and per-cycle compare process
  bit m_active, m_start_prev, m_xfer_prev, m_we_prev, m_last_prev, m_we_exp, m_last, m_ready_exp;
  logic [7:0] m_byte_prev, m_xor;
  logic [31:0] m_n;
  longint m_bytes, m_k, m_len;
  int m_status;  // 0 busy/none, 1 done, 2 error
  logic [ADDR_W+31:0] m_e;

  always @(negedge clk) begin
    if (reset) begin
      m_active = 0; m_status = 0; m_bytes = 0; m_n = 0; m_xor = 0;
      m_we_prev = 0; m_last_prev = 0;
    end else begin
      m_we_exp = 0;
      m_last = 0;
      if (m_start_prev && !(m_active && m_status == 0)) begin
        m_active = 1; m_status = 0; m_bytes = 0; m_n = 0; m_xor = 0;
      end
      if (m_xfer_prev) begin
        m_k = m_bytes;
        m_bytes++;
        if (m_k < 4) begin
          m_n = {m_n[23:0], m_byte_prev};
          m_xor ^= m_byte_prev;
          if (m_k == 3) begin
            if (m_n == 0) m_status = 1;
            else if (m_n > MAX_N) m_status = 2;
          end
        end else if (m_k < 4 + 4 * longint'(m_n)) begin
          m_xor ^= m_byte_prev;
          if (((m_k - 4) % 4) == 3) begin
            m_we_exp = 1;
            m_last = (m_k == 4 * longint'(m_n) + 3);
          end
        end else begin
          m_status = (m_byte_prev == m_xor) ? 1 : 2;
        end
      end
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (m_we_prev && m_last_prev) m_status = 1;
`endif
      if (m_bytes < 4 || m_n == 0 || m_n > MAX_N) m_len = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
      else m_len = 5 + 4 * longint'(m_n);
`else
      else m_len = 4 + 4 * longint'(m_n);
`endif
      m_ready_exp = m_active && m_status == 0 && m_bytes < m_len && !m_we_exp;

      check("imem_we", 64'(bus.imem_we), 64'(m_we_exp));
      check("in_ready", 64'(bus.in_ready), 64'(m_ready_exp));
      check("done", 64'(bus.done), 64'(m_status == 1));
      check("error", 64'(bus.error), 64'(m_status == 2));
      check("cpu_hold", 64'(bus.cpu_hold), 64'(m_status != 1));

      if (bus.imem_we) begin
        writes_seen++;
        last_addr = bus.imem_addr;
        tb_mem[bus.imem_addr] = bus.imem_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(1), 64'(0));
        end else begin
          m_e = exp_q.pop_front();
          check("wr_addr", 64'(bus.imem_addr), 64'(m_e[ADDR_W+31:32]));
          check("wr_data", 64'(bus.imem_wdata), 64'(m_e[31:0]));
        end
      end
      m_we_prev = m_we_exp;
      m_last_prev = m_last;
    end
    m_xfer_prev = !reset && bus.in_valid && bus.in_ready;
    m_byte_prev = bus.in_data;
    m_start_prev = !reset && bus.start;
  end

  // driver tasks
  task automatic pulse_start(bit with_byte);
    bus.start = 1'b1;
    if (with_byte) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA5;
    end
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, int max_gap, bit mid_start);
    int gap;
    bit acc;
    bit r;
    gap = (max_gap > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, max_gap)) : 0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data = b;
    bus.start = mid_start;
    acc = 0;
    for (int c = 0; c < 200 && !acc; c++) begin
      r = bus.in_ready;
      tick();
      bus.start = 1'b0;
      acc = r;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_byte: byte 0x%0h not accepted within 200 cycles", b);
    end
  endtask

  task automatic run_load(logic [31:0] n_hdr, int max_gap, bit bad_chk);
    logic [7:0] x;
    logic [31:0] w;
    bit ok;
    bit fin;
    x = 8'h00;
    ok = (n_hdr != 0) && (n_hdr <= MAX_N);
    writes_seen = 0;
    pulse_start($urandom_range(0, 1) == 1);
    if (ok) begin
      for (int i = 0; i < int'(n_hdr); i++) exp_q.push_back({ADDR_W'(BASE_ADDR + i), img[i]});
    end
    for (int k = 3; k >= 0; k--) begin
      send_byte(n_hdr[8*k +: 8], max_gap, 1'b0);
      x ^= n_hdr[8*k +: 8];
    end
    if (ok) begin
      for (int i = 0; i < int'(n_hdr); i++) begin
        w = img[i];
        for (int k = 3; k >= 0; k--) begin
          send_byte(w[8*k +: 8], max_gap, $urandom_range(0, 15) == 0);
          x ^= w[8*k +: 8];
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(x ^ (bad_chk ? 8'hFF : 8'h00), max_gap, 1'b0);
`endif
    end
    fin = 0;
    for (int c = 0; c < 50 && !fin; c++) begin
      fin = bus.done || bus.error;
      if (!fin) tick();
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL load_end: neither done nor error within 50 cycles (n=%0d bad_chk=%0d)", n_hdr, bad_chk);
    end
    repeat (3) tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    if (ok) begin
      for (int i = 0; i < int'(n_hdr); i++) check("mem_image", 64'(tb_mem[BASE_ADDR + i]), 64'(img[i]));
    end
  endtask

  task automatic random_img(int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom());
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) tick();

    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_imem_we", 64'(bus.imem_we), 64'(0));
    check("rst_imem_addr", 64'(bus.imem_addr), 64'(0));
    check("rst_imem_wdata", 64'(bus.imem_wdata), 64'(0));
    check("rst_cpu_hold", 64'(bus.cpu_hold), 64'(1));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_error", 64'(bus.error), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;
    repeat (2) tick();

    // basic two-word load
    img.delete();
    img.push_back(32'h20010005);
    img.push_back(32'h20020043);
    run_load(32'd2, 0, 1'b0);
    check("basic_mem0", 64'(tb_mem[0]), 64'h20010005);
    check("basic_mem1", 64'(tb_mem[1]), 64'h20020043);
    check("basic_writes", 64'(writes_seen), 64'(2));
    check("basic_done", 64'(bus.done), 64'(1));
    check("basic_hold", 64'(bus.cpu_hold), 64'(0));

    // zero-length image
    img.delete();
    run_load(32'd0, 0, 1'b0);
    check("zero_writes", 64'(writes_seen), 64'(0));
    check("zero_done", 64'(bus.done), 64'(1));
    check("zero_hold", 64'(bus.cpu_hold), 64'(0));

    // oversize header, then a good load
    run_load(32'd1025, 1, 1'b0);
    check("over_writes", 64'(writes_seen), 64'(0));
    check("over_error", 64'(bus.error), 64'(1));
    check("over_hold", 64'(bus.cpu_hold), 64'(1));
    random_img(3);
    run_load(32'd3, 2, 1'b0);
    check("after_over_writes", 64'(writes_seen), 64'(3));
    check("after_over_done", 64'(bus.done), 64'(1));

    // random sizes with gaps and stray start pulses
    for (int t = 0; t < 5; t++) begin
      n = int'($urandom_range(1, 16));
      random_img(n);
      run_load(32'(n), 3, 1'b0);
      check("rand_writes", 64'(writes_seen), 64'(n));
    end

    // full-depth load
    random_img(DEPTH);
    run_load(32'(DEPTH), 2, 1'b0);
    check("full_writes", 64'(writes_seen), 64'(DEPTH));
    check("full_last_addr", 64'(last_addr), 64'(DEPTH - 1));

`ifdef IMEM_LOADER_CHECKSUM_EN
    img.delete();
    img.push_back(32'h20010005);
    img.push_back(32'h20020043);
    run_load(32'd2, 1, 1'b0);
    check("chk_ok_done", 64'(bus.done), 64'(1));
    run_load(32'd2, 1, 1'b1);
    check("chk_bad_error", 64'(bus.error), 64'(1));
    check("chk_bad_hold", 64'(bus.cpu_hold), 64'(1));
    check("chk_bad_writes", 64'(writes_seen), 64'(2));
`endif

    // reset after the first of three words
    random_img(3);
    writes_seen = 0;
    pulse_start(1'b0);
    exp_q.push_back({ADDR_W'(BASE_ADDR), img[0]});
    for (int k = 3; k >= 0; k--) send_byte(8'(32'd3 >> (8*k)), 0, 1'b0);
    for (int k = 3; k >= 0; k--) send_byte(8'(img[0] >> (8*k)), 0, 1'b0);
    repeat (2) tick();
    send_byte(8'(img[1] >> 24), 0, 1'b0);
    send_byte(8'(img[1] >> 16), 0, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_rst_state", 64'(dbg_state), 64'(0));
    check("mid_rst_hold", 64'(bus.cpu_hold), 64'(1));
    check("mid_rst_done", 64'(bus.done), 64'(0));
    check("mid_rst_ready", 64'(bus.in_ready), 64'(0));
    reset = 1'b0;
    repeat (10) tick();
    check("mid_rst_writes", 64'(writes_seen), 64'(1));
    check("mid_rst_mem0", 64'(tb_mem[BASE_ADDR]), 64'(img[0]));
    check("mid_rst_exp_q", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
